alu_share_arbiter: RTL and testbench

//  Shares one thirty_two_bit_alu instance between NREQ requesters.
//  - Arbitrates by round-robin and latches the winner's operands.
//  - Drives the ALU from registers and captures R/Cout/V.
//  - Returns the result to the winner through a valid/ready response handshake.
//  - Sits between the issue logic of several clients and the shared ALU datapath.

---
 rtl/alu_share_pkg.sv | 28 ++
 rtl/alu_share_arbiter_rr_arbiter.sv | 38 +++
 rtl/thirty_two_bit_alu.sv | 45 ++++
 rtl/alu_share_arbiter.sv | 148 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_pkg
// Description : Opcodes, FSM encoding and opcode legality check shared by the
//               ALU-sharing arbiter and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_share_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_share_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; scans from last_grant+1
//               with wrap-around and returns a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NREQ);

  always_comb begin
    int  w_idx;
    logic w_found;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(last_grant) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = IDX_W'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/thirty_two_bit_alu.sv
`default_nettype none
// ============================================================================
// Module      : thirty_two_bit_alu
// Description : 32-bit AND/OR/ADD/SLT ALU; cin also inverts operand B, so
//               cin=1 with f=10 is subtract. Flags are zero for logic ops.
// Revision    : 1.0 - initial release
// ============================================================================
module thirty_two_bit_alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  f,
  input  logic        cin,
  input  logic        less,
  output logic [31:0] r,
  output logic        cout,
  output logic        v
);

  logic [31:0] w_bb;
  logic [32:0] w_sum;
  logic        w_ovf;
  logic        w_set;

  assign w_bb  = cin ? ~b : b;
  assign w_sum = {1'b0, a} + {1'b0, w_bb} + {32'd0, cin};
  assign w_ovf = (a[31] == w_bb[31]) && (w_sum[31] != a[31]);
  // Sign of the true difference, corrected for overflow; less is the
  // cascade input for building wider comparators from this slice.
  assign w_set = w_sum[31] ^ w_ovf;

  assign cout = f[1] & w_sum[32];
  assign v    = f[1] & w_ovf;

  always_comb begin
    r = '0;
    case (f)
      2'b00:   r = a & w_bb;
      2'b01:   r = a | w_bb;
      2'b10:   r = w_sum[31:0];
      default: r = {31'd0, w_set | less};
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one 32-bit ALU among NREQ clients with
//               valid/ready request and response handshakes.
//               Optional per-requester grant counters: ALU_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter
  import alu_share_pkg::*;
#(
  parameter int NREQ = 2
`ifdef ALU_STATS_EN
  ,
  parameter int STATS_W = 16
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [3*NREQ-1:0]    req_op,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_r,
  output logic                 rsp_cout,
  output logic                 rsp_v,
  output logic                 rsp_err
`ifdef ALU_STATS_EN
  ,
  output logic [STATS_W*NREQ-1:0] grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_gidx;
  logic [IDX_W-1:0]  w_gidx;
  logic [NREQ-1:0]   w_grant;
  logic [2:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       w_alu_r;
  logic              w_alu_cout;
  logic              w_alu_v;
  logic              w_accept;
  logic              w_rsp_done;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (r_last),
    .grant      (w_grant),
    .grant_idx  (w_gidx)
  );

  // Operands come only from the latched copies, so clients may change their
  // ports freely once accepted.
  thirty_two_bit_alu u_alu (
    .a    (r_a),
    .b    (r_b),
    .f    (r_op[1:0]),
    .cin  (r_op[2]),
    .less (1'b0),
    .r    (w_alu_r),
    .cout (w_alu_cout),
    .v    (w_alu_v)
  );

  assign w_accept   = (r_state == S_IDLE) && (|req_valid);
  assign w_rsp_done = (r_state == S_RESP) && rsp_ready[r_gidx];

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    rsp_valid = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = w_grant;
        if (|req_valid) w_next = S_EXEC;
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        rsp_valid[r_gidx] = 1'b1;
        if (rsp_ready[r_gidx]) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_last   <= IDX_W'(NREQ - 1);
      r_gidx   <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      rsp_r    <= '0;
      rsp_cout <= 1'b0;
      rsp_v    <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_gidx <= w_gidx;
        r_op   <= req_op[3*w_gidx +: 3];
        r_a    <= req_a[32*w_gidx +: 32];
        r_b    <= req_b[32*w_gidx +: 32];
      end
      if (r_state == S_EXEC) begin
        if (op_is_legal(r_op)) begin
          rsp_r    <= w_alu_r;
          rsp_cout <= w_alu_cout;
          rsp_v    <= w_alu_v;
          rsp_err  <= 1'b0;
        end else begin
          rsp_r    <= '0;
          rsp_cout <= 1'b0;
          rsp_v    <= 1'b0;
          rsp_err  <= 1'b1;
        end
      end
      if (w_rsp_done) r_last <= r_gidx;
    end
  end

`ifdef ALU_STATS_EN
  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_stats
      logic [STATS_W-1:0] r_cnt;
      always_ff @(posedge clk) begin
        if (rst)
          r_cnt <= '0;
        else if (w_accept && w_grant[i] && !(&r_cnt))
          r_cnt <= r_cnt + STATS_W'(1);
      end
      assign grant_cnt[STATS_W*i +: STATS_W] = r_cnt;
    end
  endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed plus randomized self-checking bench for the shared
//               ALU arbiter (build with ALU_STATS_EN to check counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

  localparam int NREQ = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [3*NREQ-1:0]    req_op;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [NREQ-1:0]      rsp_ready;
  logic [31:0]          rsp_r;
  logic                 rsp_cout;
  logic                 rsp_v;
  logic                 rsp_err;
`ifdef ALU_STATS_EN
  logic [16*NREQ-1:0]   grant_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_cout  (rsp_cout),
    .rsp_v     (rsp_v),
    .rsp_err   (rsp_err)
`ifdef ALU_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {err, cout, v, r} from the arithmetic meaning of each opcode.
  function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint    d;
    logic [31:0] r;
    logic      c;
    logic      v;
    r = '0; c = 1'b0; v = 1'b0; d = 0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: begin
        r = a + b;
        c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        d = longint'($signed(a)) + longint'($signed(b));
        v = (d != longint'($signed(r)));
      end
      3'b110, 3'b111: begin
        c = (a >= b);
        d = longint'($signed(a)) - longint'($signed(b));
        v = (d != longint'($signed(a - b)));
        r = (op == 3'b110) ? (a - b) : {31'd0, ($signed(a) < $signed(b))};
      end
      default: return {1'b1, 34'd0};
    endcase
    return {1'b0, c, v, r};
  endfunction

  task automatic run_op(input int id, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int stall, input string tag);
    logic [34:0]     e;
    logic [NREQ-1:0] oh;
    int              n;
    e  = model(op, a, b);
    oh = NREQ'(1) << id;
    req_valid[id]      = 1'b1;
    req_op[3*id +: 3]  = op;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("%s grant", tag), 64'(n < 20), 64'd1);
    tick();
    // Scramble live ports after acceptance; the result must not follow them.
    req_valid[id]      = 1'b0;
    req_op[3*id +: 3]  = 3'($urandom);
    req_a[32*id +: 32] = $urandom;
    req_b[32*id +: 32] = $urandom;
    check($sformatf("%s exec_no_rsp", tag), 64'(rsp_valid), 64'd0);
    tick();
    check($sformatf("%s rsp_valid", tag), 64'(rsp_valid), 64'(oh));
    check($sformatf("%s result", tag), 64'({rsp_err, rsp_cout, rsp_v, rsp_r}), 64'(e));
    for (int s = 0; s < stall; s++) begin
      tick();
      check($sformatf("%s hold_ready", tag), 64'(req_ready), 64'd0);
      check($sformatf("%s hold_valid", tag), 64'(rsp_valid), 64'(oh));
      check($sformatf("%s hold_data", tag), 64'({rsp_err, rsp_cout, rsp_v, rsp_r}), 64'(e));
    end
    rsp_ready[id] = 1'b1;
    tick();
    rsp_ready[id] = 1'b0;
    check($sformatf("%s released", tag), 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [2:0]  ops [NREQ];
    logic [31:0] as  [NREQ];
    logic [31:0] bs  [NREQ];
    logic [NREQ-1:0] exp_rdy;
    logic [NREQ-1:0] exp_rsp;
    int gid;

    rst = 1'b1; req_valid = '0; rsp_ready = '0;
    req_op = '0; req_a = '0; req_b = '0;
    tick(); tick();
    check("reset outputs", 64'({req_ready, rsp_valid, rsp_err, rsp_cout, rsp_v, rsp_r}), 64'd0);
    rst = 1'b0;
    tick();

    req_valid = 2'b11;
    #1;
    check("first grant req0", 64'(req_ready), 64'b01);
    req_valid = 2'b00;
    tick();
    check("dropped request ignored", 64'(rsp_valid), 64'd0);

    run_op(0, 3'b010, 32'hAAAAAAAA, 32'h55555555, 0, "t1_add");
    check("t1_add value", 64'({rsp_err, rsp_cout, rsp_v}), 64'd0);
    run_op(1, 3'b110, 32'h0000FFFF, 32'hFFFF0000, 0, "t2_sub");
    run_op(1, 3'b111, 32'hAAAAAAAA, 32'h55555555, 0, "t2_slt");

    // Backpressure with the other requester waiting; dropped before its grant.
    req_valid[1] = 1'b1;
    req_op[5:3]  = 3'b010;
    run_op(0, 3'b001, $urandom, $urandom, 5, "t4_stall");
    req_valid[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4 no_phantom_rsp", 64'(rsp_valid), 64'd0);
    end

    run_op(1, 3'b011, 32'hFFFFFFFF, 32'h1, 1, "t5_illegal");
    run_op(1, 3'b010, 32'h7FFFFFFF, 32'h1, 0, "t5_after");

    for (int i = 0; i < 24; i++) begin
      run_op(int'($urandom_range(0, NREQ - 1)), 3'($urandom_range(0, 7)),
             $urandom, $urandom, int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
    end

    // Saturated load: both always valid, responses always consumed.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      ops[k] = (k == 0) ? 3'b010 : 3'b110;
      as[k]  = $urandom;
      bs[k]  = $urandom;
      req_op[3*k +: 3]  = ops[k];
      req_a[32*k +: 32] = as[k];
      req_b[32*k +: 32] = bs[k];
    end
    req_valid = '1;
    rsp_ready = '1;
    #1;
    for (int c = 0; c < 12; c++) begin
      gid     = (c / 3) % NREQ;
      exp_rdy = (c % 3 == 0) ? (NREQ'(1) << gid) : '0;
      exp_rsp = (c % 3 == 2) ? (NREQ'(1) << gid) : '0;
      check($sformatf("t3 ready c%0d", c), 64'(req_ready), 64'(exp_rdy));
      check($sformatf("t3 rsp c%0d", c), 64'(rsp_valid), 64'(exp_rsp));
      if (c % 3 == 2)
        check($sformatf("t3 data c%0d", c), 64'({rsp_err, rsp_cout, rsp_v, rsp_r}),
              64'(model(ops[gid], as[gid], bs[gid])));
      tick();
    end
    req_valid = '0;
    rsp_ready = '0;
    tick();

    // Reset while executing a request from requester 1.
    req_valid = 2'b10;
    req_op[5:3] = 3'b010; req_a[63:32] = 32'h1234; req_b[63:32] = 32'h1;
    #1;
    check("t6 req1 granted", 64'(req_ready), 64'b10);
    tick();
    req_valid = '0;
    rsp_ready = '1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t6 no rsp after reset", 64'({rsp_valid, rsp_r}), 64'd0);
      tick();
    end
    rsp_ready = '0;
    req_valid = 2'b11;
    #1;
    check("t6 req0 wins after reset", 64'(req_ready), 64'b01);
    req_valid = '0;
    tick();
    run_op(0, 3'b000, $urandom, $urandom, 0, "t6_r0");
    for (int i = 0; i < 3; i++)
      run_op(1, 3'b001, $urandom, $urandom, 0, $sformatf("t6_r1_%0d", i));
`ifdef ALU_STATS_EN
    check("grant_cnt", 64'(grant_cnt), 64'({16'd3, 16'd1}));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
